gray_range_counter: RTL and testbench

Parametrised successor to the basic up/down Gray counter, producing a Gray-coded count bounded by runtime limits.
- Adds per-cycle wrap or saturate mode, Gray-or-binary load, synchronous clear, and a registered glitch-free Gray output suitable for CDC pointers.
- Adds explicit handling of out-of-range counts and invalid limit configurations.
- Sits behind async-FIFO pointer logic and sequencers that need a bounded Gray index.

---
 rtl/gray_range_counter.sv | 105 ++++++++++
 tb/tb_gray_range_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gray_range_counter.sv
// Bounded up/down counter with runtime limits, wrap/saturate modes and a
// registered Gray-coded copy of the count.
module gray_range_counter #(
  parameter int              WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_count,
  input  logic             dir,
  input  logic             mode_sat,
  input  logic [WIDTH-1:0] up_limit,
  input  logic [WIDTH-1:0] down_limit,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap_pulse,
  output logic             sat_hit,
  output logic             range_err,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  // All outputs are plain registers, meaningful every cycle; there is no
  // handshake: a new value is presented after every rising edge.
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] load_bin;
  logic             cfg_bad;
  logic             wrap_n;
  logic             sat_n;
  logic             range_n;

  assign cfg_bad = (down_limit > up_limit);

  // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_count >> i);
    end
  end

  always_comb begin
    next_bin = count_bin;
    wrap_n   = 1'b0;
    sat_n    = 1'b0;
    range_n  = 1'b0;
    if (clr) begin
      next_bin = RST_VAL;
    end else if (load) begin
      next_bin = load_gray ? load_bin : load_count;
    end else if (en) begin
      if (cfg_bad) begin
        next_bin = count_bin;
      end else if (count_bin > up_limit) begin
        next_bin = up_limit;
        range_n  = 1'b1;
      end else if (count_bin < down_limit) begin
        next_bin = down_limit;
        range_n  = 1'b1;
      end else if (dir) begin
        if (count_bin != up_limit) begin
          next_bin = count_bin + 1'b1;
        end else if (!mode_sat) begin
          next_bin = down_limit;
          wrap_n   = 1'b1;
        end else begin
          sat_n = 1'b1;
        end
      end else begin
        if (count_bin != down_limit) begin
          next_bin = count_bin - 1'b1;
        end else if (!mode_sat) begin
          next_bin = up_limit;
          wrap_n   = 1'b1;
        end else begin
          sat_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_bin  <= RST_VAL;
      count_gray <= RST_GRAY;
      wrap_pulse <= 1'b0;
      sat_hit    <= 1'b0;
      range_err  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      count_bin  <= next_bin;
      count_gray <= next_bin ^ (next_bin >> 1);
      wrap_pulse <= wrap_n;
      sat_hit    <= sat_n;
      range_err  <= range_n;
      cfg_err    <= cfg_bad;
    end
  end

endmodule

// File: tb/tb_gray_range_counter.sv
// Directed bench for gray_range_counter (WIDTH=4, RST_VAL=3) with an
// expected-value queue drained by an independent monitor.
module tb_gray_range_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic         load_gray = 1'b0;
  logic [W-1:0] load_count = '0;
  logic         dir = 1'b1;
  logic         mode_sat = 1'b0;
  logic [W-1:0] up_limit = 4'd15;
  logic [W-1:0] down_limit = 4'd0;
  logic [W-1:0] count_bin;
  logic [W-1:0] count_gray;
  logic         wrap_pulse;
  logic         sat_hit;
  logic         range_err;
  logic         cfg_err;

  // entry: {step, bin[3:0], gray[3:0], wrap, sat, range, cfg}
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] prev_gray = '0;

  gray_range_counter #(.WIDTH(W), .RST_VAL(4'd3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load),
    .load_gray(load_gray), .load_count(load_count), .dir(dir),
    .mode_sat(mode_sat), .up_limit(up_limit), .down_limit(down_limit),
    .count_bin(count_bin), .count_gray(count_gray), .wrap_pulse(wrap_pulse),
    .sat_hit(sat_hit), .range_err(range_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [12:0] mk(input logic stp, input logic [W-1:0] b,
                                     input logic w, input logic s,
                                     input logic r, input logic c);
    return {stp, b, gray(b), w, s, r, c};
  endfunction

  // One clock with the current inputs; expectation describes the registered result.
  task automatic tick(input logic stp, input logic [W-1:0] b, input logic w,
                      input logic s, input logic r, input logic c);
    @(posedge clk);
    #1;
    exp_q.push_back(mk(stp, b, w, s, r, c));
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      logic [11:0] act;
      e   = exp_q.pop_front();
      act = {count_bin, count_gray, wrap_pulse, sat_hit, range_err, cfg_err};
      checks++;
      if (act !== e[11:0]) begin
        errors++;
        $display("FAIL outputs t=%0t bin/gray/w/s/r/c actual %h/%b/%b%b%b%b required %h/%b/%b%b%b%b",
                 $time, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                 e[11:8], e[7:4], e[3], e[2], e[1], e[0]);
      end
      if (e[12]) begin
        checks++;
        if ($countones(prev_gray ^ count_gray) != 1) begin
          errors++;
          $display("FAIL gray_step t=%0t prev %b actual %b required one-bit change",
                   $time, prev_gray, count_gray);
        end
      end
      prev_gray = count_gray;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    #1 exp_q.push_back(mk(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // count 3 -> 9 over full range, then clear
    en = 1'b1; dir = 1'b1;
    for (int v = 4; v <= 9; v++) tick(1'b1, 4'(v), 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    tick(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;

    // limits 2..5, wrap mode, counting up from 2
    up_limit = 4'd5; down_limit = 4'd2;
    en = 1'b0; load = 1'b1; load_count = 4'd2;
    tick(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // saturate downward at 2, then turn around
    mode_sat = 1'b1; dir = 1'b0;
    tick(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    dir = 1'b1;
    tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Gray load of 1101 (binary 9), then clamp to up_limit
    en = 1'b0; load = 1'b1; load_gray = 1'b1; load_count = 4'b1101;
    tick(1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; load_gray = 1'b0; en = 1'b1;
    tick(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    tick(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // invalid limits: hold, load still applies, recovery
    en = 1'b1; down_limit = 4'd7; up_limit = 4'd4;
    tick(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    load = 1'b1; load_count = 4'd6;
    tick(1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    load = 1'b0; down_limit = 4'd0; up_limit = 4'd15; mode_sat = 1'b0;
    tick(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    // equal limits: wrap pulse every enabled cycle
    down_limit = 4'd8; up_limit = 4'd8;
    tick(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    down_limit = 4'd0; up_limit = 4'd15;

    // full range downward wrap 0 -> 15
    en = 1'b0; load = 1'b1; load_count = 4'd0;
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    tick(1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);

    // clr beats load
    clr = 1'b1; load = 1'b1; load_count = 4'd10;
    tick(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; load = 1'b0; dir = 1'b1;

    // async reset in the middle of a counting cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1 exp_q.push_back(mk(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue size actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
